regfile_mp: RTL and testbench

- Parametrised successor to the 2-read/1-write integer register file.
- Generalised width, depth and read-port count; configurable hardwired-zero entry 0.
- Adds a sequential clear engine: after reset, or on request, it zeroes every entry one per cycle, and flags busy while doing so.
- Sits between the ID stage (read ports) and the WB stage (write port). Core stalls ID while busy=1.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_rd_port.sv | 51 +++++
 rtl/regfile_mp.sv | 102 ++++++++++
 tb/tb_regfile_mp.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
// Forwarding is selected with the REGFILE_BYPASS_EN macro in regfile_rd_port.
package regfile_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefAddrW = 5;
  localparam int unsigned DefNumRd = 2;

  typedef enum logic [0:0] {
    StIdle,
    StClear
  } state_e;

  localparam logic [DefDataW-1:0] ZeroWord = '0;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: reset/busy/enable/zero-register masking plus optional
// same-cycle write forwarding when REGFILE_BYPASS_EN is defined.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              rst,
  input  logic              i_busy,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  input  logic [DATA_W-1:0] i_arr_data,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic w_zero_hit;

  assign w_zero_hit = (ZERO_REG != 0) && (i_raddr == '0);

`ifdef REGFILE_BYPASS_EN
  logic w_bypass_hit;

  // The zero-register check on waddr is implied: a zero hit on raddr wins first.
  assign w_bypass_hit = i_we && !i_busy && (i_raddr == i_waddr);
`else
  logic w_unused_wr;

  assign w_unused_wr = ^{i_we, i_waddr, i_wdata};
`endif

  always_comb begin
    o_rdata = '0;
    if (rst || i_busy || !i_re) begin
      o_rdata = '0;
    end else if (w_zero_hit) begin
      o_rdata = '0;
`ifdef REGFILE_BYPASS_EN
    end else if (w_bypass_hit) begin
      o_rdata = i_wdata;
`endif
    end else begin
      o_rdata = i_arr_data;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with a sequential clear engine.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned NUM_RD   = DefNumRd,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_we,
  input  logic [ADDR_W-1:0]        i_waddr,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic [NUM_RD-1:0]        i_re,
  input  logic [NUM_RD*ADDR_W-1:0] i_raddr,
  output logic [NUM_RD*DATA_W-1:0] o_rdata,
  input  logic                     i_clr_req,
  output logic                     o_busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [ADDR_W-1:0]   r_ptr;
  logic                r_busy;
  logic                w_clr_we;
  logic                w_user_we;
  logic                w_wr_zero;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DATA_W-1:0]   w_arr_rd [NUM_RD];

  always_comb begin
    w_state_nxt = r_state;
    w_clr_we    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_clr_req) begin
          w_state_nxt = StClear;
        end
      end
      StClear: begin
        w_clr_we = 1'b1;
        // Last entry is written this cycle; no extra terminal cycle.
        if (&r_ptr) begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StClear;
      r_ptr   <= '0;
      r_busy  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == StClear);
      r_ptr   <= (r_state == StClear) ? r_ptr + 1'b1 : '0;
    end
  end

  assign o_busy    = r_busy;
  assign w_wr_zero = (ZERO_REG != 0) && (i_waddr == '0);
  assign w_user_we = i_we && (r_state == StIdle) && !w_wr_zero;

  // No reset on the array: the clear engine initialises every entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_clr_we) begin
        r_mem[r_ptr] <= ZeroWord[DATA_W-1:0];
      end else if (w_user_we) begin
        r_mem[i_waddr] <= i_wdata;
      end
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd_port
    assign w_arr_rd[g] = r_mem[i_raddr[g*ADDR_W +: ADDR_W]];

    regfile_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_rd_port (
      .rst        (rst),
      .i_busy     (r_busy),
      .i_re       (i_re[g]),
      .i_raddr    (i_raddr[g*ADDR_W +: ADDR_W]),
      .i_arr_data (w_arr_rd[g]),
      .i_we       (i_we),
      .i_waddr    (i_waddr),
      .i_wdata    (i_wdata),
      .o_rdata    (o_rdata[g*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus queues expected values per cycle, a monitor
// compares on the falling edge. A second instance uses ZERO_REG=0.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [1:0]  re;
  logic [9:0]  raddr;
  logic        clr_req;
  logic [63:0] rdata;
  logic [63:0] rdata_z0;
  logic        busy;
  logic        busy_z0;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  logic [31:0] act;

  always #5 clk = ~clk;

  regfile_mp #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .NUM_RD   (2),
    .ZERO_REG (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_we      (we),
    .i_waddr   (waddr),
    .i_wdata   (wdata),
    .i_re      (re),
    .i_raddr   (raddr),
    .o_rdata   (rdata),
    .i_clr_req (clr_req),
    .o_busy    (busy)
  );

  regfile_mp #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .NUM_RD   (2),
    .ZERO_REG (0)
  ) dut_z0 (
    .clk       (clk),
    .rst       (rst),
    .i_we      (we),
    .i_waddr   (waddr),
    .i_wdata   (wdata),
    .i_re      (re),
    .i_raddr   (raddr),
    .o_rdata   (rdata_z0),
    .i_clr_req (clr_req),
    .o_busy    (busy_z0)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every queued expectation belongs to the cycle it was pushed in.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      case (e.sel)
        0:       act = rdata[31:0];
        1:       act = rdata[63:32];
        2:       act = {31'b0, busy};
        default: act = rdata_z0[31:0];
      endcase
      checks++;
      if (e.cyc != cyc || act !== e.val) begin
        errors++;
        $display("FAIL %s (cycle %0d): got %h expected %h", e.name, cyc, act, e.val);
      end
    end
  end

  task automatic push(input string name, input int sel, input logic [31:0] val);
    exp_t x;
    x.cyc  = cyc;
    x.sel  = sel;
    x.val  = val;
    x.name = name;
    q.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    re    = 2'b11;
    raddr = {a1, a0};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; re = 2'b11; raddr = '0; clr_req = 1'b0;

    // Reset held two cycles, then a full 32-cycle clear.
    step();
    rd(5'd3, 5'd4);
    push("rst_busy", 2, 32'd1);
    push("rst_rd0", 0, 32'd0);
    push("rst_rd1", 1, 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), 5'(31 - i));
      push("init_busy", 2, 32'd1);
      push("init_rd0", 0, 32'd0);
      push("init_rd1", 1, 32'd0);
      step();
    end
    push("init_busy_fall", 2, 32'd0);
    for (int i = 1; i < 32; i++) begin
      rd(5'(i), 5'(i));
      push("post_init_rd0", 0, 32'd0);
      push("post_init_rd1", 1, 32'd0);
      step();
    end

    // Basic write then read.
    re = 2'b00; we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    step();
    we = 1'b0;
    rd(5'd5, 5'd0);
    push("wr_r5", 0, 32'hDEADBEEF);
    push("rd_r0", 1, 32'd0);
    step();

    // Write to r0: suppressed with ZERO_REG=1, ordinary with ZERO_REG=0.
    re = 2'b00; we = 1'b1; waddr = 5'd0; wdata = 32'h12345678;
    step();
    we = 1'b0;
    rd(5'd0, 5'd0);
    push("r0_zero_reg1", 0, 32'd0);
    push("r0_zero_reg0", 3, 32'h12345678);
    step();

    // Same-cycle write/read of r7.
    re = 2'b00; we = 1'b1; waddr = 5'd7; wdata = 32'h1;
    step();
    we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5;
    rd(5'd7, 5'd5);
`ifdef REGFILE_BYPASS_EN
    push("bypass_same", 0, 32'hA5A5A5A5);
`else
    push("nobypass_same", 0, 32'h1);
`endif
    push("bypass_other", 1, 32'hDEADBEEF);
    step();
    we = 1'b0;
    push("bypass_next", 0, 32'hA5A5A5A5);
    step();

    // Fill, then clear with a dropped write and an ignored second request.
    re = 2'b00;
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; waddr = 5'(i); wdata = 32'h80000000 | 32'(i);
      step();
    end
    we = 1'b0;
    rd(5'd1, 5'd31);
    push("fill_r1", 0, 32'h80000001);
    push("fill_r31", 1, 32'h8000001F);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int i = 0; i < 32; i++) begin
      we = (i == 20); waddr = 5'd9; wdata = 32'hFF;
      clr_req = (i == 31);
      rd(5'd9, 5'd1);
      push("clr_busy", 2, 32'd1);
      push("clr_rd0", 0, 32'd0);
      push("clr_rd1", 1, 32'd0);
      step();
    end
    we = 1'b0; clr_req = 1'b0;
    rd(5'd9, 5'd1);
    push("clr_busy_fall", 2, 32'd0);
    push("clr_r9", 0, 32'd0);
    push("clr_r1", 1, 32'd0);
    step();
    rd(5'd31, 5'd20);
    push("clr_no_restart", 2, 32'd0);
    push("clr_r31", 0, 32'd0);
    push("clr_r20", 1, 32'd0);
    step();

    // Reset at ptr=10 restarts a full clear.
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      push("rclr_busy", 2, 32'd1);
      step();
    end
    rst = 1'b1;
    rd(5'd5, 5'd7);
    push("rclr_rst_busy", 2, 32'd1);
    push("rclr_rst_rd0", 0, 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      push("rclr_busy_restart", 2, 32'd1);
      step();
    end
    push("rclr_busy_fall", 2, 32'd0);
    push("rclr_r5", 0, 32'd0);
    push("rclr_r7", 1, 32'd0);
    step();
    step();

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
